matmul_operand_sequencer: RTL and testbench
===========================================

Name: matmul_operand_sequencer

Overview:
- Control and datapath front-end for the 5x5 signed 8-bit matrix multiply.
- On start, latches operand matrices A and B and streams one row-of-A / column-of-B pair per cycle to a free-running inner-product unit (element 0 to 24).
- Captures each returned 8-bit product and overflow flag through a latency-matched pipeline, assembles the 200-bit result matrix C, and pulses done.
- Sits between the coprocessor instruction/register layer and the inner-product unit.

Parameters:
- IP_LATENCY, 1, clock edges from the inner-product unit sampling its operands to its result being sampled here; legal range 1..4.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin an operation; sampled only in IDLE.
- mat_a  in  200  matrix A; element (r,c) at bits [(r*5+c)*8 +: 8], two's complement.
- mat_b  in  200  matrix B; same packing.
- ip_lin  out  40  row r of A; byte k at [k*8 +: 8] = A(r,k).
- ip_col  out  40  column c of B; byte k at [k*8 +: 8] = B(k,c).
- ip_valid  out  1  high while ip_lin/ip_col carry a live pair.
- ip_result  in  8  signed product returned by the inner-product unit.
- ip_ovf  in  1  overflow flag returned with ip_result.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- mat_c  out  200  result matrix, same packing; updated only at completion.
- ovf_map  out  25  bit k = ip_ovf captured for element k = r*5+c.
- ovf_any  out  1  OR of ovf_map.

Behaviour:
- Reset values: all outputs 0, including ip_lin, ip_col, ip_valid, busy, done, mat_c, ovf_map and ovf_any. State is IDLE and all counters are 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE, start=1 at edge E0:
  - Latch mat_a and mat_b into internal registers; later input changes have no effect.
  - Clear the capture buffer and the internal overflow accumulator.
  - Set busy=1 and enter ISSUE.
  - Drive element 0 (r=0,c=0) on ip_lin/ip_col with ip_valid=1. These outputs are registered and change at E0.
- ISSUE:
  - At each edge, advance element k to k+1, with c counting fastest: c wraps 4 to 0 and increments r.
  - Element k is driven between edges E(k) and E(k+1).
  - At the edge that would issue element 25, go to DRAIN, set ip_valid=0 and set ip_lin/ip_col to 0.
- Capture pipeline:
  - The issue index and a valid bit travel through an (IP_LATENCY+1)-stage shift register.
  - ip_result and ip_ovf for element k are sampled at edge E(k+1+IP_LATENCY).
  - Each sample is written into capture byte k and overflow bit k.
- DRAIN:
  - At the edge capturing element 24, i.e. E(25+IP_LATENCY), copy the capture buffer to mat_c and the overflow bits to ovf_map.
  - In the same edge, set ovf_any, set done=1 and busy=0, and return to IDLE.
  - Latency: done is high in the cycle after E(25+IP_LATENCY).
  - For IP_LATENCY=1, done follows E26.
- done lasts exactly one cycle.
- mat_c, ovf_map and ovf_any hold until the next completion. They are not cleared by start.
- start while busy=1 is ignored and has no effect on the running operation.
- A start in the cycle where done=1 is accepted, since the block is in IDLE. The new operation then proceeds normally.
- No arithmetic is done here. Results are stored verbatim, with no saturation or overflow correction.
- rst mid-operation:
  - Everything returns to reset values immediately, including mat_c.
  - done does not pulse.
  - In-flight captures are discarded.

Test Plan:
- A=identity, B(r,c)=r*5+c, IP_LATENCY=1, paired with a behavioural inner-product unit: mat_c==B, ovf_map=0, done high exactly in the cycle after E26, busy high cycles E0..E25.
- A all 0x02, B all 0x03: every mat_c byte 0x1E, ovf_any=0; repeat with IP_LATENCY=3 and check done after E28 with identical mat_c.
- A all 0x7F, B all 0x7F: every mat_c byte 0x05 (low byte of 80645), ovf_map=25'h1FFFFFF, ovf_any=1.
- A all 0xFF (-1), B=identity: every mat_c byte 0xFF, ovf_map=0; check ip_col for c=2 equals 40'h0000010000.
- Hold start high and change mat_a/mat_b mid-run: second start ignored, result reflects latched operands; start in the done cycle launches a second run that completes 26 cycles later.
- Assert rst while element 10 is on ip_lin: all outputs 0 at once, no done pulse; a subsequent start completes with correct mat_c.

Source files
------------

// File: rtl/matmul_operand_sequencer.sv
// Operand sequencer for the 5x5 signed 8-bit matrix multiply: streams row/column
// pairs to a free-running inner-product unit and assembles the returned bytes into C.
module matmul_operand_sequencer #(
  parameter int IP_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] mat_a,
  input  logic [199:0] mat_b,
  output logic [39:0]  ip_lin,
  output logic [39:0]  ip_col,
  output logic         ip_valid,
  input  logic [7:0]   ip_result,
  input  logic         ip_ovf,
  output logic         busy,
  output logic         done,
  output logic [199:0] mat_c,
  output logic [24:0]  ovf_map,
  output logic         ovf_any
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t       r_state;
  state_t       w_stateNext;

  logic [199:0] r_matA;
  logic [199:0] r_matB;
  logic [191:0] r_capBuf;
  logic [23:0]  r_ovfBuf;
  logic [2:0]   r_row;
  logic [2:0]   r_col;
  logic         r_pipeValid [0:IP_LATENCY];
  logic [4:0]   r_pipeIdx   [0:IP_LATENCY];

  logic         w_load;
  logic         w_advance;
  logic         w_finish;
  logic         w_capture;
  logic         w_lastCapture;
  logic         w_nextValid;
  logic [2:0]   w_nextRow;
  logic [2:0]   w_nextCol;
  logic [4:0]   w_nextIdx;
  logic [199:0] w_srcA;
  logic [199:0] w_srcB;
  logic [39:0]  w_nextLinVec;
  logic [39:0]  w_nextColVec;

  // Stage 0 of the pipe is the element currently on ip_lin/ip_col; stage IP_LATENCY
  // is the element whose product is on ip_result this cycle.
  assign ip_valid      = r_pipeValid[0];
  assign w_capture     = r_pipeValid[IP_LATENCY];
  assign w_lastCapture = r_pipeValid[IP_LATENCY] && (r_pipeIdx[IP_LATENCY] == 5'd24);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (r_pipeIdx[0] == 5'd24) begin
          w_stateNext = DRAIN;
        end else begin
          w_advance = 1'b1;
        end
      end
      DRAIN: begin
        if (w_lastCapture) begin
          w_finish    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Column index runs fastest; an idle or draining issue slot drives element 0 as zeros.
  always_comb begin
    w_nextValid = w_load | w_advance;
    w_nextRow   = 3'd0;
    w_nextCol   = 3'd0;
    w_nextIdx   = 5'd0;
    if (w_advance) begin
      w_nextIdx = r_pipeIdx[0] + 5'd1;
      if (r_col == 3'd4) begin
        w_nextRow = r_row + 3'd1;
      end else begin
        w_nextRow = r_row;
        w_nextCol = r_col + 3'd1;
      end
    end
  end

  // On the launch edge the operand registers are not yet loaded, so read the ports.
  assign w_srcA = w_load ? mat_a : r_matA;
  assign w_srcB = w_load ? mat_b : r_matB;

  always_comb begin
    w_nextLinVec = w_srcA[int'(w_nextRow)*40 +: 40];
    w_nextColVec = '0;
    for (int k = 0; k < 5; k++) begin
      w_nextColVec[k*8 +: 8] = w_srcB[(k*5 + int'(w_nextCol))*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_matA   <= '0;
      r_matB   <= '0;
      r_capBuf <= '0;
      r_ovfBuf <= '0;
      r_row    <= '0;
      r_col    <= '0;
      for (int s = 0; s <= IP_LATENCY; s++) begin
        r_pipeValid[s] <= 1'b0;
        r_pipeIdx[s]   <= '0;
      end
      ip_lin   <= '0;
      ip_col   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mat_c    <= '0;
      ovf_map  <= '0;
      ovf_any  <= 1'b0;
    end else begin
      r_row          <= w_nextRow;
      r_col          <= w_nextCol;
      r_pipeValid[0] <= w_nextValid;
      r_pipeIdx[0]   <= w_nextIdx;
      for (int s = 1; s <= IP_LATENCY; s++) begin
        r_pipeValid[s] <= r_pipeValid[s-1];
        r_pipeIdx[s]   <= r_pipeIdx[s-1];
      end
      ip_lin <= w_nextValid ? w_nextLinVec : '0;
      ip_col <= w_nextValid ? w_nextColVec : '0;
      done   <= w_finish;

      if (w_load) begin
        r_matA   <= mat_a;
        r_matB   <= mat_b;
        r_capBuf <= '0;
        r_ovfBuf <= '0;
        busy     <= 1'b1;
      end else if (w_capture && !w_lastCapture) begin
        r_capBuf[int'(r_pipeIdx[IP_LATENCY])*8 +: 8] <= ip_result;
        r_ovfBuf[r_pipeIdx[IP_LATENCY]]              <= ip_ovf;
      end

      // Element 24 goes straight from the inner-product port into the result.
      if (w_finish) begin
        mat_c   <= {ip_result, r_capBuf};
        ovf_map <= {ip_ovf, r_ovfBuf};
        ovf_any <= ip_ovf | (|r_ovfBuf);
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Scoreboard bench for matmul_operand_sequencer at IP_LATENCY 1 and 3, each instance
// paired with a behavioural inner-product unit of matching latency.
module tb_matmul_operand_sequencer;

  typedef struct packed {
    logic [199:0] c;
    logic [24:0]  ovf;
  } expT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0;
  logic         start3 = 1'b0;
  logic [199:0] matA = '0;
  logic [199:0] matB = '0;

  logic [39:0]  lin1, col1, lin3, col3;
  logic         valid1, valid3, busy1, busy3, done1, done3, ovfAny1, ovfAny3;
  logic [199:0] matC1, matC3;
  logic [24:0]  ovfMap1, ovfMap3;
  logic [7:0]   res1, res3;
  logic         ipOvf1, ipOvf3;

  logic [8:0]   m1Out = '0;
  logic [8:0]   m3Pipe [1:3] = '{default: '0};

  expT          sbQ[$];
  int           total = 0;
  int           bad = 0;
  logic [199:0] curA = '0;
  logic [199:0] curB = '0;
  logic [199:0] prevC1 = '0;

  matmul_operand_sequencer #(.IP_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mat_a(matA), .mat_b(matB),
    .ip_lin(lin1), .ip_col(col1), .ip_valid(valid1), .ip_result(res1), .ip_ovf(ipOvf1),
    .busy(busy1), .done(done1), .mat_c(matC1), .ovf_map(ovfMap1), .ovf_any(ovfAny1)
  );

  matmul_operand_sequencer #(.IP_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mat_a(matA), .mat_b(matB),
    .ip_lin(lin3), .ip_col(col3), .ip_valid(valid3), .ip_result(res3), .ip_ovf(ipOvf3),
    .busy(busy3), .done(done3), .mat_c(matC3), .ovf_map(ovfMap3), .ovf_any(ovfAny3)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ipCompute(input logic [39:0] lin, input logic [39:0] col);
    int s;
    s = 0;
    for (int k = 0; k < 5; k++) begin
      s += int'($signed(lin[k*8 +: 8])) * int'($signed(col[k*8 +: 8]));
    end
    return {(s > 127 || s < -128), s[7:0]};
  endfunction

  function automatic logic [39:0] rowOf(input logic [199:0] m, input int r);
    return m[r*40 +: 40];
  endfunction

  function automatic logic [39:0] colOf(input logic [199:0] m, input int c);
    logic [39:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) v[k*8 +: 8] = m[(k*5 + c)*8 +: 8];
    return v;
  endfunction

  function automatic expT refMatMul(input logic [199:0] a, input logic [199:0] b);
    expT e;
    logic [8:0] v;
    e = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        v = ipCompute(rowOf(a, r), colOf(b, c));
        e.c[(r*5 + c)*8 +: 8] = v[7:0];
        e.ovf[r*5 + c]        = v[8];
      end
    end
    return e;
  endfunction

  // Behavioural inner-product units: sample operands every edge, result emerges
  // IP_LATENCY edges later.
  always @(posedge clk) m1Out <= ipCompute(lin1, col1);
  always @(posedge clk) begin
    m3Pipe[1] <= ipCompute(lin3, col3);
    m3Pipe[2] <= m3Pipe[1];
    m3Pipe[3] <= m3Pipe[2];
  end
  assign res1   = m1Out[7:0];
  assign ipOvf1 = m1Out[8];
  assign res3   = m3Pipe[3][7:0];
  assign ipOvf3 = m3Pipe[3][8];

  task automatic expectEq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int lat, input logic [199:0] a, input logic [199:0] b,
                               input bit holdStart);
    @(negedge clk);
    matA = a;
    matB = b;
    if (lat == 3) start3 = 1'b1;
    else start1 = 1'b1;
    curA = a;
    curB = b;
    sbQ.push_back(refMatMul(a, b));
    @(posedge clk);
    @(negedge clk);
    if (!holdStart) begin
      start1 = 1'b0;
      start3 = 1'b0;
    end
  endtask

  // Entered at the falling edge just after the launch edge (n = 0).
  task automatic checkOutput(input string tag, input int lat, input bit scramble,
                             input bit checkCol2);
    int n, doneAt, busyHi, issueBad, depth;
    logic sBusy, sDone, sValid, sStart;
    logic [39:0] sLin, sCol;
    expT e;
    n = 0;
    doneAt = -1;
    busyHi = 0;
    issueBad = 0;
    while (doneAt < 0 && n < 60) begin
      sBusy  = (lat == 3) ? busy3 : busy1;
      sDone  = (lat == 3) ? done3 : done1;
      sValid = (lat == 3) ? valid3 : valid1;
      sLin   = (lat == 3) ? lin3 : lin1;
      sCol   = (lat == 3) ? col3 : col1;
      if (n < 25) begin
        if (sValid !== 1'b1 || sLin !== rowOf(curA, n / 5) || sCol !== colOf(curB, n % 5))
          issueBad++;
      end else if (n == 25) begin
        if (sValid !== 1'b0 || sLin !== 40'h0 || sCol !== 40'h0) issueBad++;
      end
      if (n == 2 && checkCol2) expectEq({tag, ".ipColC2"}, 320'(sCol), 320'(40'h0000010000));
      if (n == 3 && lat == 1) expectEq({tag, ".matCHeld"}, 320'(matC1), 320'(prevC1));
      if (n == 5 && scramble) begin
        matA = ~matA;
        matB = matB ^ {25{8'h5A}};
      end
      if (sBusy === 1'b1) busyHi++;
      if (sDone === 1'b1) doneAt = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
    expectEq({tag, ".doneCycle"}, 320'(doneAt), 320'(25 + lat));
    expectEq({tag, ".busyCycles"}, 320'(busyHi), 320'(25 + lat));
    expectEq({tag, ".issueStream"}, 320'(issueBad), 320'(0));
    depth = sbQ.size();
    expectEq({tag, ".sbDepth"}, 320'(depth), 320'(1));
    e = '0;
    if (depth > 0) e = sbQ.pop_front();
    expectEq({tag, ".matC"}, 320'((lat == 3) ? matC3 : matC1), 320'(e.c));
    expectEq({tag, ".ovfMap"}, 320'((lat == 3) ? ovfMap3 : ovfMap1), 320'(e.ovf));
    expectEq({tag, ".ovfAny"}, 320'((lat == 3) ? ovfAny3 : ovfAny1), 320'(|e.ovf));
    if (lat == 1) prevC1 = e.c;
    sStart = (lat == 3) ? start3 : start1;
    if (sStart === 1'b1) begin
      curA = matA;
      curB = matB;
      sbQ.push_back(refMatMul(matA, matB));
    end
    @(negedge clk);
    expectEq({tag, ".donePulseWidth"}, 320'((lat == 3) ? done3 : done1), 320'(0));
  endtask

  initial begin
    logic [199:0] ident, seq, rndA, rndB;
    int doneSeen, busySeen;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        ident[(r*5 + c)*8 +: 8] = (r == c) ? 8'h01 : 8'h00;
        seq[(r*5 + c)*8 +: 8]   = 8'(r*5 + c);
        rndA[(r*5 + c)*8 +: 8]  = 8'($urandom_range(0, 255));
        rndB[(r*5 + c)*8 +: 8]  = 8'($urandom_range(0, 255));
      end
    end

    repeat (3) @(negedge clk);
    expectEq("reset.dut1", 320'({lin1, col1, valid1, busy1, done1, matC1, ovfMap1, ovfAny1}), 320'(0));
    expectEq("reset.dut3", 320'({lin3, col3, valid3, busy3, done3, matC3, ovfMap3, ovfAny3}), 320'(0));
    rst = 1'b0;

    $display("[TB] identity x sequence, latency 1");
    applyStimulus(1, ident, seq, 1'b0);
    checkOutput("ident", 1, 1'b0, 1'b0);
    expectEq("ident.cEqualsB", 320'(matC1), 320'(seq));

    $display("[TB] 0x02 x 0x03, latency 1 and 3");
    applyStimulus(1, {25{8'h02}}, {25{8'h03}}, 1'b0);
    checkOutput("twos", 1, 1'b0, 1'b0);
    expectEq("twos.all1E", 320'(matC1), 320'({25{8'h1E}}));
    applyStimulus(3, {25{8'h02}}, {25{8'h03}}, 1'b0);
    checkOutput("twosLat3", 3, 1'b0, 1'b0);
    expectEq("twosLat3.all1E", 320'(matC3), 320'({25{8'h1E}}));

    $display("[TB] 0x7F x 0x7F overflow");
    applyStimulus(1, {25{8'h7F}}, {25{8'h7F}}, 1'b0);
    checkOutput("max", 1, 1'b0, 1'b0);
    expectEq("max.all05", 320'(matC1), 320'({25{8'h05}}));
    expectEq("max.ovfMapFull", 320'(ovfMap1), 320'(25'h1FFFFFF));

    $display("[TB] -1 x identity");
    applyStimulus(1, {25{8'hFF}}, ident, 1'b0);
    checkOutput("negOne", 1, 1'b0, 1'b1);
    expectEq("negOne.allFF", 320'(matC1), 320'({25{8'hFF}}));
    expectEq("negOne.ovfMapZero", 320'(ovfMap1), 320'(0));

    $display("[TB] start held high, operands changed mid-run, chained run");
    applyStimulus(1, rndA, rndB, 1'b1);
    checkOutput("held", 1, 1'b1, 1'b0);
    start1 = 1'b0;
    checkOutput("chained", 1, 1'b0, 1'b0);

    $display("[TB] reset while element 10 is issued");
    applyStimulus(1, seq, rndB, 1'b0);
    repeat (10) @(negedge clk);
    expectEq("rst.element10Lin", 320'(lin1), 320'(rowOf(curA, 2)));
    rst = 1'b1;
    #1;
    expectEq("rst.outputsZero", 320'({lin1, col1, valid1, busy1, done1, matC1, ovfMap1, ovfAny1}), 320'(0));
    void'(sbQ.pop_front());
    prevC1 = '0;
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 !== 1'b0) doneSeen++;
      if (busy1 !== 1'b0) busySeen++;
    end
    expectEq("rst.noDone", 320'(doneSeen), 320'(0));
    expectEq("rst.noBusy", 320'(busySeen), 320'(0));
    applyStimulus(1, rndA, seq, 1'b0);
    checkOutput("afterRst", 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
